// File: rtl/wbu.sv
// Write-back stage: retires one instruction per handshake, aligns/extends load data, drives a GPR write pulse.
// Latency: write visible the cycle after commit (accept edge for non-loads, data edge for loads).
// Backpressure: o_ready drops while a load waits for RAM data; it returns after data or timeout.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid / o_ready       upstream handshake (o_ready depends on state and reset only)
//   i_ram_rd_*              load enable, size/sign code, read data and its valid strobe
//   i_alu_res, i_pc         ALU result (load address for loads) and instruction PC
//   i_gpr_wr_en/id/src      destination register write request and data source select
//   o_valid, o_gpr_wr_*     registered one-cycle retire / GPR write pulse
//   o_retire_cnt, o_err     retired-instruction count and sticky RAM-timeout flag
//
// Load size code (ARGS_WIDTH = 3): bits [1:0] = log2(bytes), bit [2] = 1 for zero-extend.
//   0 = 1_S, 1 = 2_S, 2 = 4_S, 3 = 8_S, 4 = 1_U, 5 = 2_U, 6 = 4_U, 7 = 8_U
module wbu #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ARGS_WIDTH = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_ram_rd_en,
    input  logic [ARGS_WIDTH-1:0] i_ram_rd_byt,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
    input  logic                  i_ram_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_alu_res,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_gpr_wr_en,
    input  logic [4:0]            i_gpr_wr_id,
    input  logic [1:0]            i_gpr_wr_src,
    output logic                  o_valid,
    output logic                  o_gpr_wr_en,
    output logic [4:0]            o_gpr_wr_id,
    output logic [DATA_WIDTH-1:0] o_gpr_wr_data,
    output logic [63:0]           o_retire_cnt,
    output logic                  o_err
);

    localparam int OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [1:0] SRC_RAM = 2'd1;
    localparam logic [1:0] SRC_PC4 = 2'd2;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Instruction metadata held while a load waits for data
    logic [DATA_WIDTH-1:0]   alu_q, alu_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ARGS_WIDTH-1:0]   byt_q, byt_d;
    logic                    wr_en_q, wr_en_d;
    logic [4:0]              wr_id_q, wr_id_d;
    logic [1:0]              wr_src_q, wr_src_d;

    logic                    valid_q, valid_d;
    logic                    gpr_wr_en_q, gpr_wr_en_d;
    logic [4:0]              gpr_wr_id_q, gpr_wr_id_d;
    logic [DATA_WIDTH-1:0]   gpr_wr_data_q, gpr_wr_data_d;
    logic [63:0]             retire_cnt_q, retire_cnt_d;
    logic                    err_q, err_d;

    logic                    in_wait;
    logic                    accept;
    logic                    commit;
    logic [DATA_WIDTH-1:0]   eff_alu;
    logic [ADDR_WIDTH-1:0]   eff_pc;
    logic [ARGS_WIDTH-1:0]   eff_byt;
    logic                    eff_wr_en;
    logic [4:0]              eff_wr_id;
    logic [1:0]              eff_wr_src;
    logic [OFF_W-1:0]        lane_off;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]   mask;
    logic                    sign_bit;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [ADDR_WIDTH-1:0]   pc_plus4;
    logic [DATA_WIDTH-1:0]   wr_data_sel;

    assign in_wait = (state_q == S_WAIT);
    assign o_ready = (state_q == S_IDLE) & ~i_rst;
    assign accept  = i_valid & o_ready;

    // A zero-wait commit uses the live inputs; a delayed commit uses the held copy
    assign eff_alu    = in_wait ? alu_q    : i_alu_res;
    assign eff_pc     = in_wait ? pc_q     : i_pc;
    assign eff_byt    = in_wait ? byt_q    : i_ram_rd_byt;
    assign eff_wr_en  = in_wait ? wr_en_q  : i_gpr_wr_en;
    assign eff_wr_id  = in_wait ? wr_id_q  : i_gpr_wr_id;
    assign eff_wr_src = in_wait ? wr_src_q : i_gpr_wr_src;

    assign lane_off = eff_alu[OFF_W-1:0];
    assign shifted  = i_ram_rd_data >> {lane_off, 3'b000};

    // On a 32-bit datapath the 4-byte mask is already all ones, so 8-byte codes
    // naturally collapse to 4-byte behaviour.
    always_comb begin
        mask     = '1;
        sign_bit = 1'b0;
        case (eff_byt[1:0])
            2'd0: begin mask = DATA_WIDTH'(8'hFF);         sign_bit = shifted[7];  end
            2'd1: begin mask = DATA_WIDTH'(16'hFFFF);      sign_bit = shifted[15]; end
            2'd2: begin mask = DATA_WIDTH'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
            default: begin mask = '1; sign_bit = 1'b0; end
        endcase
    end

    assign load_data = (shifted & mask) | ({DATA_WIDTH{sign_bit & ~eff_byt[2]}} & ~mask);
    assign pc_plus4  = eff_pc + ADDR_WIDTH'(4);

    always_comb begin
        case (eff_wr_src)
            SRC_RAM: wr_data_sel = load_data;
            SRC_PC4: wr_data_sel = DATA_WIDTH'(pc_plus4);
            default: wr_data_sel = eff_alu;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_d         = alu_q;
        pc_d          = pc_q;
        byt_d         = byt_q;
        wr_en_d       = wr_en_q;
        wr_id_d       = wr_id_q;
        wr_src_d      = wr_src_q;
        valid_d       = 1'b0;
        gpr_wr_en_d   = 1'b0;
        gpr_wr_id_d   = gpr_wr_id_q;
        gpr_wr_data_d = gpr_wr_data_q;
        retire_cnt_d  = retire_cnt_q;
        err_d         = err_q;
        commit        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_d    = i_alu_res;
                    pc_d     = i_pc;
                    byt_d    = i_ram_rd_byt;
                    wr_en_d  = i_gpr_wr_en;
                    wr_id_d  = i_gpr_wr_id;
                    wr_src_d = i_gpr_wr_src;
                    if (!i_ram_rd_en || i_ram_rd_valid) begin
                        commit = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                if (i_ram_rd_valid) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end else if (TIMEOUT != 0) begin
                    // The counter hits TIMEOUT on this edge: abandon the load
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            valid_d       = 1'b1;
            gpr_wr_en_d   = eff_wr_en & (eff_wr_id != 5'd0);
            gpr_wr_id_d   = eff_wr_id;
            gpr_wr_data_d = wr_data_sel;
            retire_cnt_d  = retire_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            alu_q         <= '0;
            pc_q          <= '0;
            byt_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_id_q       <= '0;
            wr_src_q      <= '0;
            valid_q       <= 1'b0;
            gpr_wr_en_q   <= 1'b0;
            gpr_wr_id_q   <= '0;
            gpr_wr_data_q <= '0;
            retire_cnt_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_q         <= alu_d;
            pc_q          <= pc_d;
            byt_q         <= byt_d;
            wr_en_q       <= wr_en_d;
            wr_id_q       <= wr_id_d;
            wr_src_q      <= wr_src_d;
            valid_q       <= valid_d;
            gpr_wr_en_q   <= gpr_wr_en_d;
            gpr_wr_id_q   <= gpr_wr_id_d;
            gpr_wr_data_q <= gpr_wr_data_d;
            retire_cnt_q  <= retire_cnt_d;
            err_q         <= err_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_gpr_wr_en   = gpr_wr_en_q;
    assign o_gpr_wr_id   = gpr_wr_id_q;
    assign o_gpr_wr_data = gpr_wr_data_q;
    assign o_retire_cnt  = retire_cnt_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_wbu.sv
module tb_wbu;

    localparam int TMO = 4;
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LD = 3'd3;
    localparam logic [2:0] LBU = 3'd4, LHU = 3'd5, LWU = 3'd6;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_ram_rd_en;
    logic [2:0]  i_ram_rd_byt;
    logic [63:0] i_ram_rd_data;
    logic        i_ram_rd_valid;
    logic [63:0] i_alu_res;
    logic [31:0] i_pc;
    logic        i_gpr_wr_en;
    logic [4:0]  i_gpr_wr_id;
    logic [1:0]  i_gpr_wr_src;
    logic        o_valid;
    logic        o_gpr_wr_en;
    logic [4:0]  o_gpr_wr_id;
    logic [63:0] o_gpr_wr_data;
    logic [63:0] o_retire_cnt;
    logic        o_err;

    always #5 i_clk = ~i_clk;

    wbu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .ARGS_WIDTH(3), .TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_ram_rd_en(i_ram_rd_en), .i_ram_rd_byt(i_ram_rd_byt),
        .i_ram_rd_data(i_ram_rd_data), .i_ram_rd_valid(i_ram_rd_valid),
        .i_alu_res(i_alu_res), .i_pc(i_pc), .i_gpr_wr_en(i_gpr_wr_en),
        .i_gpr_wr_id(i_gpr_wr_id), .i_gpr_wr_src(i_gpr_wr_src),
        .o_valid(o_valid), .o_gpr_wr_en(o_gpr_wr_en), .o_gpr_wr_id(o_gpr_wr_id),
        .o_gpr_wr_data(o_gpr_wr_data), .o_retire_cnt(o_retire_cnt), .o_err(o_err)
    );

    typedef struct {
        logic [1:0]  src;
        logic        en;
        logic [4:0]  id;
        logic [63:0] alu;
        logic [31:0] pc;
        logic [2:0]  byt;
        logic [63:0] rd;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        int          e;
        logic        en;
        logic [4:0]  id;
        logic [63:0] data;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          err_at = -1;
    bit          chk_en = 1'b0;
    exp_t        q[$];
    logic [63:0] model_cnt = 64'd0;
    logic [4:0]  last_id = 5'd0;
    logic [63:0] last_data = 64'd0;
    vec_t        tbl[8];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Load result straight from the size/sign rules
    function automatic logic [63:0] load_val(input logic [2:0] byt, input logic [63:0] addr,
                                             input logic [63:0] rdata);
        logic [63:0] v;
        logic [63:0] lim;
        int          off;
        off = int'(addr % 64'd8);
        v   = rdata >> (8 * off);
        if (byt[1:0] != 2'd3) begin
            lim = 64'd1 << (8 << byt[1:0]);
            v   = v % lim;
            if (!byt[2] && v >= (lim >> 1)) v = v - lim;
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_data(input vec_t v);
        logic [31:0] p4;
        p4 = v.pc + 32'd4;
        case (v.src)
            2'd1:    return load_val(v.byt, v.alu, v.rd);
            2'd2:    return {32'd0, p4};
            default: return v.alu;
        endcase
    endfunction

    function automatic vec_t mk(input logic [1:0] src, input logic en, input logic [4:0] id,
                                input logic [63:0] alu, input logic [31:0] pc,
                                input logic [2:0] byt, input logic [63:0] rd,
                                input logic [63:0] exp);
        vec_t v;
        v.src = src; v.en = en; v.id = id; v.alu = alu; v.pc = pc;
        v.byt = byt; v.rd = rd; v.exp = exp;
        return v;
    endfunction

    task automatic push(input vec_t v);
        exp_t x;
        x.e    = cyc + 1;
        x.en   = v.en && (v.id != 5'd0);
        x.id   = v.id;
        x.data = exp_data(v);
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic quiet();
        i_valid        = 1'b0;
        i_ram_rd_en    = 1'b0;
        i_ram_rd_valid = 1'b0;
    endtask

    task automatic issue(input vec_t v, input logic rdv);
        chk("ready_at_issue", 64'(o_ready), 64'd1);
        i_valid        = 1'b1;
        i_ram_rd_en    = (v.src == 2'd1);
        i_ram_rd_byt   = v.byt;
        i_ram_rd_data  = v.rd;
        i_ram_rd_valid = rdv;
        i_alu_res      = v.alu;
        i_pc           = v.pc;
        i_gpr_wr_en    = v.en;
        i_gpr_wr_id    = v.id;
        i_gpr_wr_src   = v.src;
        if (v.src != 2'd1 || rdv) push(v);
    endtask

    // Cycle-by-cycle comparison against the expected retire stream
    always @(negedge i_clk) begin
        if (chk_en) begin
            while (q.size() > 0 && q[0].e < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_retire: no o_valid at cycle %0d required for rd %0d", q[0].e, q[0].id);
                void'(q.pop_front());
            end
            if (o_valid) begin
                if (q.size() == 0 || q[0].e != cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_retire: o_valid=1 at cycle %0d required 0", cyc);
                end else begin
                    model_cnt = model_cnt + 64'd1;
                    chk("m_wr_en", 64'(o_gpr_wr_en), 64'(q[0].en));
                    chk("m_wr_id", 64'(o_gpr_wr_id), 64'(q[0].id));
                    chk("m_wr_data", o_gpr_wr_data, q[0].data);
                    last_id   = q[0].id;
                    last_data = q[0].data;
                    void'(q.pop_front());
                end
            end else begin
                chk("m_idle_wr_en", 64'(o_gpr_wr_en), 64'd0);
                chk("m_hold_id", 64'(o_gpr_wr_id), 64'(last_id));
                chk("m_hold_data", o_gpr_wr_data, last_data);
            end
            chk("m_retire_cnt", o_retire_cnt, model_cnt);
            chk("m_err", 64'(o_err), 64'((err_at >= 0) && (cyc >= err_at)));
        end
    end

    initial begin
        vec_t v;
        tbl[0] = mk(2'd1, 1'b1, 5'd10, 64'h204, 32'd0, LW,  64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        tbl[1] = mk(2'd1, 1'b1, 5'd11, 64'h307, 32'd0, LBU, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB);
        tbl[2] = mk(2'd1, 1'b1, 5'd12, 64'h400, 32'd0, LD,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        tbl[3] = mk(2'd1, 1'b1, 5'd13, 64'h506, 32'd0, LH,  64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
        tbl[4] = mk(2'd1, 1'b1, 5'd14, 64'h604, 32'd0, LWU, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
        tbl[5] = mk(2'd3, 1'b1, 5'd15, 64'hDEAD, 32'd0, LB, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_DEAD);
        tbl[6] = mk(2'd0, 1'b0, 5'd16, 64'h99, 32'd0, LB,   64'd0, 64'h0000_0000_0000_0099);
        tbl[7] = mk(2'd2, 1'b1, 5'd17, 64'h5, 32'hFFFF_FFFC, LB, 64'd0, 64'h0000_0000_0000_0000);

        i_rst = 1'b1;
        i_alu_res = 64'd0; i_pc = 32'd0; i_ram_rd_byt = 3'd0; i_ram_rd_data = 64'd0;
        i_gpr_wr_en = 1'b0; i_gpr_wr_id = 5'd0; i_gpr_wr_src = 2'd0;
        quiet();

        repeat (3) tick();
        chk("ready_in_reset", 64'(o_ready), 64'd0);
        i_rst = 1'b0;
        #1;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_wr_en", 64'(o_gpr_wr_en), 64'd0);
        chk("rst_wr_id", 64'(o_gpr_wr_id), 64'd0);
        chk("rst_wr_data", o_gpr_wr_data, 64'd0);
        chk("rst_retire", o_retire_cnt, 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk_en = 1'b1;

        // Back-to-back ALU writes
        issue(mk(2'd0, 1'b1, 5'd5, 64'h1234, 32'd0, LB, 64'd0, 64'd0), 1'b0);
        tick();
        chk("b2b_first_en", 64'(o_gpr_wr_en), 64'd1);
        chk("b2b_first_id", 64'(o_gpr_wr_id), 64'd5);
        chk("b2b_first_data", o_gpr_wr_data, 64'h1234);
        issue(mk(2'd0, 1'b1, 5'd6, 64'h55, 32'd0, LB, 64'd0, 64'd0), 1'b0);
        tick();
        quiet();
        chk("b2b_second_en", 64'(o_gpr_wr_en), 64'd1);
        chk("b2b_second_id", 64'(o_gpr_wr_id), 64'd6);
        chk("b2b_second_data", o_gpr_wr_data, 64'h55);
        chk("b2b_retire", o_retire_cnt, 64'd2);
        tick();

        // Signed byte load with data three cycles late
        v = mk(2'd1, 1'b1, 5'd8, 64'h100, 32'd0, LB, 64'd0, 64'd0);
        issue(v, 1'b0);
        tick();
        quiet();
        chk("lb_wait_ready0", 64'(o_ready), 64'd0);
        tick();
        chk("lb_wait_ready1", 64'(o_ready), 64'd0);
        tick();
        chk("lb_wait_ready2", 64'(o_ready), 64'd0);
        i_ram_rd_valid = 1'b1;
        i_ram_rd_data  = 64'h80;
        v.rd = 64'h80;
        push(v);
        tick();
        i_ram_rd_valid = 1'b0;
        chk("lb_ready_back", 64'(o_ready), 64'd1);
        chk("lb_en", 64'(o_gpr_wr_en), 64'd1);
        chk("lb_data", o_gpr_wr_data, 64'hFFFF_FFFF_FFFF_FF80);

        // Zero-wait unsigned halfword at offset 2
        issue(mk(2'd1, 1'b1, 5'd9, 64'h102, 32'd0, LHU, 64'h0000_0000_BEEF_1234, 64'd0), 1'b1);
        tick();
        quiet();
        chk("lhu_ready", 64'(o_ready), 64'd1);
        chk("lhu_data", o_gpr_wr_data, 64'h0000_0000_0000_BEEF);

        // PC+4 source, then the same with rd = 0
        issue(mk(2'd2, 1'b1, 5'd1, 64'h1111, 32'h8000_0000, LB, 64'd0, 64'd0), 1'b0);
        tick();
        chk("jal_en", 64'(o_gpr_wr_en), 64'd1);
        chk("jal_data", o_gpr_wr_data, 64'h0000_0000_8000_0004);
        issue(mk(2'd2, 1'b1, 5'd0, 64'h1111, 32'h8000_0000, LB, 64'd0, 64'd0), 1'b0);
        tick();
        quiet();
        chk("jal_x0_en", 64'(o_gpr_wr_en), 64'd0);
        chk("jal_x0_valid", 64'(o_valid), 64'd1);
        chk("jal_x0_retire", o_retire_cnt, 64'd6);

        // Alignment / extension / source table, back to back
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i], 1'b1);
            tick();
            chk($sformatf("tbl%0d_data", i), o_gpr_wr_data, tbl[i].exp);
            chk($sformatf("tbl%0d_en", i), 64'(o_gpr_wr_en), 64'(tbl[i].en));
        end
        quiet();
        tick();
        chk("tbl_retire", o_retire_cnt, 64'd14);

        // RAM read timeout
        issue(mk(2'd1, 1'b1, 5'd20, 64'h700, 32'd0, LW, 64'd0, 64'd0), 1'b0);
        err_at = cyc + 1 + TMO;
        tick();
        quiet();
        repeat (3) tick();
        chk("tmo_err_before", 64'(o_err), 64'd0);
        chk("tmo_ready_before", 64'(o_ready), 64'd0);
        tick();
        chk("tmo_err", 64'(o_err), 64'd1);
        chk("tmo_ready", 64'(o_ready), 64'd1);
        chk("tmo_no_write", 64'(o_gpr_wr_en), 64'd0);
        chk("tmo_retire", o_retire_cnt, 64'd14);
        i_ram_rd_valid = 1'b1;
        i_ram_rd_data  = 64'hFFFF;
        tick();
        i_ram_rd_valid = 1'b0;
        chk("stray_rdv_valid", 64'(o_valid), 64'd0);
        issue(mk(2'd0, 1'b1, 5'd7, 64'h77, 32'd0, LB, 64'd0, 64'd0), 1'b0);
        tick();
        quiet();
        chk("post_tmo_id", 64'(o_gpr_wr_id), 64'd7);
        chk("post_tmo_data", o_gpr_wr_data, 64'h77);
        chk("post_tmo_err_sticky", 64'(o_err), 64'd1);
        tick();
        chk("post_tmo_retire", o_retire_cnt, 64'd15);

        // Reset while a load is waiting
        issue(mk(2'd1, 1'b1, 5'd21, 64'h800, 32'd0, LD, 64'd0, 64'd0), 1'b0);
        tick();
        quiet();
        chk("rw_wait_ready", 64'(o_ready), 64'd0);
        chk_en = 1'b0;
        i_rst  = 1'b1;
        #1;
        chk("rw_ready_in_rst", 64'(o_ready), 64'd0);
        tick();
        i_rst = 1'b0;
        q.delete();
        model_cnt = 64'd0;
        last_id   = 5'd0;
        last_data = 64'd0;
        err_at    = -1;
        chk_en    = 1'b1;
        i_ram_rd_valid = 1'b1;
        i_ram_rd_data  = 64'h1234_5678;
        #1;
        chk("rw_ready", 64'(o_ready), 64'd1);
        chk("rw_err", 64'(o_err), 64'd0);
        chk("rw_retire", o_retire_cnt, 64'd0);
        chk("rw_data", o_gpr_wr_data, 64'd0);
        chk("rw_id", 64'(o_gpr_wr_id), 64'd0);
        tick();
        i_ram_rd_valid = 1'b0;
        chk("rw_no_valid", 64'(o_valid), 64'd0);
        chk("rw_no_write", 64'(o_gpr_wr_en), 64'd0);
        repeat (3) tick();

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
